// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes and the carry rule.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder; the only arithmetic in the serial adder.
module full_adder_cell
  import serial_adder_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = maj3(i_a, i_b, i_c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit per clock, LSB first, through one full-adder cell.
// Operands enter over valid/ready; {o_carry,o_sum} is held until the consumer acks.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_valid,
  input  logic             i_ready
);

  localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            c_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic            carry_q;
  logic            valid_q;
  logic            ready_q;

  logic            fa_s;
  logic            fa_c;

  full_adder_cell u_fa (
    .i_a (a_q[cnt_q]),
    .i_b (b_q[cnt_q]),
    .i_c (c_q),
    .o_s (fa_s),
    .o_c (fa_c)
  );

  // FSM, counter, operand latch, running carry and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            a_q     <= i_a;
            b_q     <= i_b;
            c_q     <= i_carry;
            sum_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          // Bits above cnt stay 0 because sum_q was cleared at accept.
          sum_q[cnt_q] <= fa_s;
          c_q          <= fa_c;
          if (cnt_q == CNT_LAST) begin
            carry_q <= fa_c;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder (WIDTH=4) against a plain-arithmetic model.
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             i_clk;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_carry;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_valid;
  logic             i_ready;

  int checks;
  int failures;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_carry (i_carry),
    .o_sum   (o_sum),
    .o_carry (o_carry),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // One complete transaction; dly = cycles of consumer backpressure in DONE,
  // noisy = drive junk operands with i_valid high while the block is busy.
  task automatic run_op(input int a, input int b, input int c, input int dly, input bit noisy);
    int exp_sum;
    int exp_carry;
    int total;
    int k;
    int guard;
    total     = a + b + c;
    exp_sum   = total % (1 << WIDTH);
    exp_carry = total >> WIDTH;
    guard = 0;
    while (!o_ready && guard < 20) begin
      step();
      guard++;
    end
    check_eq("ready_before_accept", int'(o_ready), 1);
    i_valid = 1'b1;
    i_a     = WIDTH'(a);
    i_b     = WIDTH'(b);
    i_carry = 1'(c);
    step();
    check_eq("ready_low_after_accept", int'(o_ready), 0);
    i_valid = noisy;
    if (noisy) begin
      i_a     = 4'd9;
      i_b     = WIDTH'($urandom);
      i_carry = 1'($urandom);
    end
    k = 0;
    while (!o_valid && k < 20) begin
      check_eq("run_partial_sum", int'(o_sum), exp_sum & ((1 << k) - 1));
      check_eq("run_ready_low", int'(o_ready), 0);
      step();
      k++;
    end
    check_eq("latency", k, WIDTH);
    check_eq("sum", int'(o_sum), exp_sum);
    check_eq("carry", int'(o_carry), exp_carry);
    for (int d = 0; d < dly; d++) begin
      step();
      check_eq("hold_valid", int'(o_valid), 1);
      check_eq("hold_sum", int'(o_sum), exp_sum);
      check_eq("hold_carry", int'(o_carry), exp_carry);
      check_eq("hold_ready_low", int'(o_ready), 0);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check_eq("ack_valid_low", int'(o_valid), 0);
    check_eq("ack_back_to_idle", int'(o_ready), 1);
    i_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_a      = '0;
    i_b      = '0;
    i_carry  = 1'b0;
    i_ready  = 1'b0;
    step();
    step();
    check_eq("reset_ready", int'(o_ready), 1);
    check_eq("reset_valid", int'(o_valid), 0);
    check_eq("reset_sum", int'(o_sum), 0);
    check_eq("reset_carry", int'(o_carry), 0);
    i_rst = 1'b0;
    step();

    run_op(5, 3, 0, 0, 1'b0);
    run_op(15, 1, 0, 1, 1'b0);
    run_op(15, 15, 1, 0, 1'b0);
    run_op(6, 2, 1, 3, 1'b1);

    // Reset landing on the second RUN edge discards the operation.
    i_valid = 1'b1;
    i_a     = 4'd13;
    i_b     = 4'd7;
    i_carry = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check_eq("midrun_rst_ready", int'(o_ready), 1);
    check_eq("midrun_rst_valid", int'(o_valid), 0);
    check_eq("midrun_rst_sum", int'(o_sum), 0);
    check_eq("midrun_rst_carry", int'(o_carry), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("midrun_rst_no_valid", int'(o_valid), 0);
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(a, b, c, int'($urandom_range(0, 3)), 1'($urandom));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
